// File: rtl/pq_pkg.sv
// Shared types for the priority-queue device and its clients.
// Client FSM state encoding lives here so benches and checkers can decode the debug port.
package pq_pkg;

    localparam int PQ_CAPACITY = 8;
    localparam int KEY_WIDTH   = 8;
    localparam int VAL_WIDTH   = 8;
    localparam int CNT_W       = $clog2(PQ_CAPACITY + 1);

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_EWAIT = 2'd1,
        S_DRAIN = 2'd2,
        S_DWAIT = 2'd3
    } pqc_state_t;

endpackage

// File: rtl/pq_sort_client.sv
// Batch sorter client: loads a batch into the PQ, then drains it in ascending key order.
// Handshakes: a transfer happens on a cycle where valid && ready at the rising clk edge;
// valid never waits on ready, and out_kv is held while out_valid && !out_ready.
module pq_sort_client
    import pq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  kv_t              in_kv,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output kv_t              out_kv,
    output logic             out_last,
    output logic             pq_enq,
    output logic             pq_deq,
    output kv_t              pq_kvi,
    input  kv_t              pq_kvo,
    input  logic             pq_full,
    input  logic             pq_empty,
    input  logic             pq_busy,
    output logic [CNT_W-1:0] count,
    output pqc_state_t       dbg_state
);

    pqc_state_t state;
    logic       last_seen;
    // The PQ only raises busy one cycle after a strobe, so the first wait cycle is skipped.
    logic       guard;

    assign dbg_state = state;
    assign out_kv    = pq_kvo;
    assign pq_kvi    = in_kv;
    assign pq_enq    = in_valid && in_ready;
    assign pq_deq    = out_valid && out_ready;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            S_LOAD:  in_ready  = !rst && !pq_busy && !pq_full && !last_seen;
            S_DRAIN: begin
                out_valid = !rst && !pq_busy && (count != '0);
                out_last  = out_valid && (count == CNT_W'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            count     <= '0;
            last_seen <= 1'b0;
            guard     <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (pq_enq) begin
                        count     <= count + CNT_W'(1);
                        last_seen <= in_last;
                        guard     <= 1'b1;
                        state     <= S_EWAIT;
                    end
                end
                S_EWAIT: begin
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (!pq_busy) begin
                        state <= last_seen ? S_DRAIN : S_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (pq_deq) begin
                        count <= count - CNT_W'(1);
                        guard <= 1'b1;
                        state <= S_DWAIT;
                    end
                end
                S_DWAIT: begin
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (!pq_busy) begin
                        if (count == '0) begin
                            last_seen <= 1'b0;
                            state     <= S_LOAD;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    a_no_enq_deq_overlap: assert property (@(posedge clk) disable iff (rst) !(pq_enq && pq_deq));
    a_no_count_overflow:  assert property (@(posedge clk) disable iff (rst) pq_enq |-> (count != CNT_W'(PQ_CAPACITY)));
    a_no_count_underflow: assert property (@(posedge clk) disable iff (rst) pq_deq |-> (count != '0));
    // count is the authority; an empty PQ while we still expect items means the PQ misbehaved.
    a_pq_not_empty:       assert property (@(posedge clk) disable iff (rst) out_valid |-> !pq_empty);

endmodule
